// File: rtl/fcl_multi_controller_if.sv
// rtl/fcl_multi_controller_if.sv - command/loader handshake bundle for fcl_multi_controller
interface fcl_multi_controller_if #(
    parameter int NUM_CFG = 4,
    parameter int IW      = $clog2(NUM_CFG)
);
    logic [NUM_CFG-1:0] i_cmd_load;
    logic               i_FCL_allowed;
    logic               i_is_loading;
    logic               o_go;
    logic [IW-1:0]      o_cfg_idx;
    logic               o_req_valid;
    logic               o_pending;
    logic               o_done;
    logic               o_timeout;

    // Command decoder, sequencer and loader side
    modport master (
        output i_cmd_load, i_FCL_allowed, i_is_loading,
        input  o_go, o_cfg_idx, o_req_valid, o_pending, o_done, o_timeout
    );

    // Controller side
    modport slave (
        input  i_cmd_load, i_FCL_allowed, i_is_loading,
        output o_go, o_cfg_idx, o_req_valid, o_pending, o_done, o_timeout
    );
endinterface

// File: rtl/fcl_multi_controller.sv
// rtl/fcl_multi_controller.sv - N-config field-config load controller (optional watchdog: FCL_TIMEOUT_EN)
module fcl_multi_controller #(
    parameter int NUM_CFG        = 4,
    parameter int BOOT_CFG       = 0,
    parameter int BOOT_LOAD      = 1,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int IW             = $clog2(NUM_CFG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fcl_multi_controller_if.slave bus
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_START    = 2'd1;
    localparam logic [1:0] ST_WAIT_END = 2'd2;

    localparam logic [1:0]    RST_STATE = (BOOT_LOAD != 0) ? ST_START : ST_IDLE;
    localparam logic [IW-1:0] RST_IDX   = (BOOT_LOAD != 0) ? IW'(BOOT_CFG) : '0;
    localparam logic          RST_REQ   = (BOOT_LOAD != 0);

    logic [1:0]    state;
    logic [IW-1:0] cur_idx;
    logic          req_valid;
    logic [IW-1:0] pend_idx;
    logic          pend_valid;
    logic          done_q;
    logic [IW-1:0] cmd_idx;
    logic          cmd_any;
    logic          wd_hit;
    logic          load_end;

    // Lowest set command bit wins when several configs are requested together
    always_comb begin
        cmd_idx = '0;
        for (int k = NUM_CFG - 1; k >= 0; k--) begin
            if (bus.i_cmd_load[k]) begin
                cmd_idx = IW'(k);
            end
        end
    end

    assign cmd_any = |bus.i_cmd_load;

`ifdef FCL_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] wd_cnt;
    logic          timeout_q;

    assign wd_hit = (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) && bus.i_is_loading;

    // Watchdog counts WAIT_END cycles, cleared while passing through START
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == ST_START) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT_END) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Abort pulse registered alongside the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == ST_WAIT_END) && wd_hit;
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    assign wd_hit        = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    assign load_end = (state == ST_WAIT_END) && (!bus.i_is_loading || wd_hit);

    // Request capture, pending slot and load sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_STATE;
            cur_idx    <= RST_IDX;
            req_valid  <= RST_REQ;
            pend_idx   <= '0;
            pend_valid <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= load_end;
            case (state)
                ST_IDLE: begin
                    if (cmd_any) begin
                        cur_idx   <= cmd_idx;
                        req_valid <= 1'b1;
                    end
                    if (req_valid && bus.i_FCL_allowed) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cmd_any) begin
                        pend_idx   <= cmd_idx;
                        pend_valid <= 1'b1;
                    end
                    state <= ST_WAIT_END;
                end
                ST_WAIT_END: begin
                    if (load_end) begin
                        state      <= ST_IDLE;
                        pend_valid <= 1'b0;
                        if (cmd_any) begin
                            cur_idx   <= cmd_idx;
                            req_valid <= 1'b1;
                        end else if (pend_valid) begin
                            cur_idx   <= pend_idx;
                            req_valid <= 1'b1;
                        end else begin
                            req_valid <= 1'b0;
                        end
                    end else if (cmd_any) begin
                        pend_idx   <= cmd_idx;
                        pend_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_go        = (state == ST_START);
    assign bus.o_cfg_idx   = cur_idx;
    assign bus.o_req_valid = req_valid;
    assign bus.o_pending   = pend_valid;
    assign bus.o_done      = done_q;
endmodule

// File: tb/tb_fcl_multi_controller.sv
// tb/tb_fcl_multi_controller.sv - randomized self-checking bench for fcl_multi_controller
module tb_fcl_multi_controller;
    localparam int NUM_CFG = 4;
    localparam int IW      = 2;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    fcl_multi_controller_if #(.NUM_CFG(NUM_CFG)) bus ();

    fcl_multi_controller #(
        .NUM_CFG(NUM_CFG),
        .BOOT_CFG(2),
        .BOOT_LOAD(1),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        bus.i_cmd_load = '0;
        bus.i_FCL_allowed = 1'b0;
        bus.i_is_loading = 1'b0;
        repeat (3) tick();
        total++; if (bus.o_req_valid !== 1'b1) $display("FAIL rst_req_valid got %b want 1", bus.o_req_valid); else passed++;
        total++; if (bus.o_cfg_idx !== IW'(2)) $display("FAIL rst_cfg_idx got %0d want 2", bus.o_cfg_idx); else passed++;
        total++; if (bus.o_pending !== 1'b0) $display("FAIL rst_pending got %b want 0", bus.o_pending); else passed++;
        total++; if (bus.o_done !== 1'b0) $display("FAIL rst_done got %b want 0", bus.o_done); else passed++;
        total++; if (bus.o_timeout !== 1'b0) $display("FAIL rst_timeout got %b want 0", bus.o_timeout); else passed++;
        rst_n = 1'b1;
        total++; if (bus.o_go !== 1'b1) $display("FAIL boot_go got %b want 1", bus.o_go); else passed++;
        tick();
        total++; if (bus.o_go !== 1'b0) $display("FAIL boot_go_width got %b want 0", bus.o_go); else passed++;
        bus.i_is_loading = 1'b1;
        repeat (5) tick();
        total++; if (bus.o_done !== 1'b0) $display("FAIL boot_done_early got %b want 0", bus.o_done); else passed++;
        bus.i_is_loading = 1'b0;
        tick();
        total++; if (bus.o_done !== 1'b1) $display("FAIL boot_done got %b want 1", bus.o_done); else passed++;
        total++; if (bus.o_req_valid !== 1'b0) $display("FAIL boot_req_cleared got %b want 0", bus.o_req_valid); else passed++;
        tick();
        total++; if (bus.o_done !== 1'b0) $display("FAIL boot_done_width got %b want 0", bus.o_done); else passed++;
    endtask

    task automatic test_cmd_allow;
        bus.i_FCL_allowed = 1'b0;
        bus.i_cmd_load = 4'b0010;
        tick();
        bus.i_cmd_load = '0;
        total++; if (bus.o_req_valid !== 1'b1 || bus.o_cfg_idx !== IW'(1)) $display("FAIL cmd_capture got v=%b idx=%0d want v=1 idx=1", bus.o_req_valid, bus.o_cfg_idx); else passed++;
        tick();
        tick();
        total++; if (bus.o_go !== 1'b0) $display("FAIL go_without_allow got %b want 0", bus.o_go); else passed++;
        bus.i_FCL_allowed = 1'b1;
        tick();
        total++; if (bus.o_go !== 1'b1) $display("FAIL go_after_allow got %b want 1", bus.o_go); else passed++;
        tick();
        total++; if (bus.o_go !== 1'b0) $display("FAIL go_one_cycle got %b want 0", bus.o_go); else passed++;
        tick();
        total++; if (bus.o_done !== 1'b1 || bus.o_req_valid !== 1'b0) $display("FAIL zero_len_done got d=%b v=%b want d=1 v=0", bus.o_done, bus.o_req_valid); else passed++;
        bus.i_FCL_allowed = 1'b0;
    endtask

    task automatic test_priority;
        bus.i_FCL_allowed = 1'b0;
        bus.i_cmd_load = 4'b1100;
        tick();
        total++; if (bus.o_cfg_idx !== IW'(2)) $display("FAIL lowest_wins got %0d want 2", bus.o_cfg_idx); else passed++;
        bus.i_cmd_load = 4'b0001;
        tick();
        bus.i_cmd_load = '0;
        total++; if (bus.o_cfg_idx !== IW'(0)) $display("FAIL last_wins got %0d want 0", bus.o_cfg_idx); else passed++;
    endtask

    task automatic test_pending;
        // Request 0 is already held from test_priority
        bus.i_FCL_allowed = 1'b1;
        tick();
        total++; if (bus.o_go !== 1'b1 || bus.o_cfg_idx !== IW'(0)) $display("FAIL pend_first_go got go=%b idx=%0d want go=1 idx=0", bus.o_go, bus.o_cfg_idx); else passed++;
        bus.i_FCL_allowed = 1'b0;
        tick();
        bus.i_is_loading = 1'b1;
        bus.i_cmd_load = 4'b1000;
        tick();
        bus.i_cmd_load = '0;
        total++; if (bus.o_pending !== 1'b1) $display("FAIL pend_set got %b want 1", bus.o_pending); else passed++;
        tick();
        bus.i_is_loading = 1'b0;
        tick();
        total++; if (bus.o_done !== 1'b1 || bus.o_cfg_idx !== IW'(3) || bus.o_req_valid !== 1'b1 || bus.o_pending !== 1'b0) $display("FAIL pend_promote got d=%b idx=%0d v=%b p=%b want d=1 idx=3 v=1 p=0", bus.o_done, bus.o_cfg_idx, bus.o_req_valid, bus.o_pending); else passed++;
        bus.i_FCL_allowed = 1'b1;
        tick();
        total++; if (bus.o_go !== 1'b1) $display("FAIL pend_second_go got %b want 1", bus.o_go); else passed++;
        bus.i_FCL_allowed = 1'b0;
        tick();
        tick();
        total++; if (bus.o_done !== 1'b1 || bus.o_req_valid !== 1'b0) $display("FAIL pend_second_done got d=%b v=%b want d=1 v=0", bus.o_done, bus.o_req_valid); else passed++;
    endtask

    task automatic test_random;
        logic [3:0] v;
        int exp_idx;
        bit exp_valid;
        int pend_idx;
        bit pend_v;
        int busy;
        int n;
        bus.i_FCL_allowed = 1'b0;
        exp_valid = 1'b0;
        exp_idx = 0;
        for (int it = 0; it < 20; it++) begin
            if (!exp_valid) begin
                n = $urandom_range(1, 3);
                for (int c = 0; c < n; c++) begin
                    v = 4'($urandom_range(1, 15));
                    bus.i_cmd_load = v;
                    exp_idx = lowest(v);
                    tick();
                end
                bus.i_cmd_load = '0;
                exp_valid = 1'b1;
                total++; if (bus.o_req_valid !== 1'b1 || bus.o_cfg_idx !== IW'(exp_idx) || bus.o_go !== 1'b0) $display("FAIL rnd_idle_req it=%0d got v=%b idx=%0d go=%b want v=1 idx=%0d go=0", it, bus.o_req_valid, bus.o_cfg_idx, bus.o_go, exp_idx); else passed++;
            end
            bus.i_FCL_allowed = 1'b1;
            tick();
            total++; if (bus.o_go !== 1'b1 || bus.o_cfg_idx !== IW'(exp_idx)) $display("FAIL rnd_go it=%0d got go=%b idx=%0d want go=1 idx=%0d", it, bus.o_go, bus.o_cfg_idx, exp_idx); else passed++;
            bus.i_FCL_allowed = 1'($urandom_range(0, 1));
            tick();
            pend_v = 1'b0;
            pend_idx = 0;
            busy = $urandom_range(0, 5);
            for (int b = 0; b < busy; b++) begin
                bus.i_is_loading = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    v = 4'($urandom_range(1, 15));
                    bus.i_cmd_load = v;
                    pend_idx = lowest(v);
                    pend_v = 1'b1;
                end
                tick();
                bus.i_cmd_load = '0;
                total++; if (bus.o_pending !== pend_v || bus.o_go !== 1'b0) $display("FAIL rnd_wait it=%0d got p=%b go=%b want p=%b go=0", it, bus.o_pending, bus.o_go, pend_v); else passed++;
            end
            bus.i_is_loading = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                v = 4'($urandom_range(1, 15));
                bus.i_cmd_load = v;
                exp_idx = lowest(v);
                exp_valid = 1'b1;
            end else if (pend_v) begin
                exp_idx = pend_idx;
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            tick();
            bus.i_cmd_load = '0;
            bus.i_FCL_allowed = 1'b0;
            total++; if (bus.o_done !== 1'b1 || bus.o_req_valid !== exp_valid || bus.o_pending !== 1'b0) $display("FAIL rnd_done it=%0d got d=%b v=%b p=%b want d=1 v=%b p=0", it, bus.o_done, bus.o_req_valid, bus.o_pending, exp_valid); else passed++;
            if (exp_valid) begin
                total++; if (bus.o_cfg_idx !== IW'(exp_idx)) $display("FAIL rnd_next_idx it=%0d got %0d want %0d", it, bus.o_cfg_idx, exp_idx); else passed++;
            end
        end
        if (exp_valid) begin
            // Drain the outstanding request so later tests start idle
            bus.i_FCL_allowed = 1'b1;
            tick();
            bus.i_FCL_allowed = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_timeout;
        bus.i_FCL_allowed = 1'b0;
        bus.i_cmd_load = 4'b0100;
        tick();
        bus.i_cmd_load = '0;
        bus.i_FCL_allowed = 1'b1;
        tick();
        bus.i_FCL_allowed = 1'b0;
        tick();
        bus.i_is_loading = 1'b1;
`ifdef FCL_TIMEOUT_EN
        repeat (15) tick();
        total++; if (bus.o_done !== 1'b0 || bus.o_timeout !== 1'b0) $display("FAIL wd_early got d=%b t=%b want d=0 t=0", bus.o_done, bus.o_timeout); else passed++;
        tick();
        total++; if (bus.o_done !== 1'b1 || bus.o_timeout !== 1'b1 || bus.o_req_valid !== 1'b0) $display("FAIL wd_abort got d=%b t=%b v=%b want d=1 t=1 v=0", bus.o_done, bus.o_timeout, bus.o_req_valid); else passed++;
        tick();
        total++; if (bus.o_go !== 1'b0 || bus.o_timeout !== 1'b0) $display("FAIL wd_idle got go=%b t=%b want go=0 t=0", bus.o_go, bus.o_timeout); else passed++;
        bus.i_is_loading = 1'b0;
`else
        repeat (40) tick();
        total++; if (bus.o_done !== 1'b0 || bus.o_timeout !== 1'b0 || bus.o_req_valid !== 1'b1) $display("FAIL long_load got d=%b t=%b v=%b want d=0 t=0 v=1", bus.o_done, bus.o_timeout, bus.o_req_valid); else passed++;
        bus.i_is_loading = 1'b0;
        tick();
        total++; if (bus.o_done !== 1'b1 || bus.o_timeout !== 1'b0) $display("FAIL long_load_end got d=%b t=%b want d=1 t=0", bus.o_done, bus.o_timeout); else passed++;
`endif
        tick();
    endtask

    task automatic test_reset_midload;
        bus.i_cmd_load = 4'b0001;
        bus.i_FCL_allowed = 1'b1;
        tick();
        bus.i_cmd_load = '0;
        tick();
        bus.i_FCL_allowed = 1'b0;
        tick();
        bus.i_is_loading = 1'b1;
        bus.i_cmd_load = 4'b1000;
        tick();
        bus.i_cmd_load = '0;
        total++; if (bus.o_pending !== 1'b1) $display("FAIL mid_pending got %b want 1", bus.o_pending); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (bus.o_pending !== 1'b0 || bus.o_cfg_idx !== IW'(2) || bus.o_req_valid !== 1'b1 || bus.o_go !== 1'b1 || bus.o_done !== 1'b0) $display("FAIL mid_reset got p=%b idx=%0d v=%b go=%b d=%b want p=0 idx=2 v=1 go=1 d=0", bus.o_pending, bus.o_cfg_idx, bus.o_req_valid, bus.o_go, bus.o_done); else passed++;
        bus.i_is_loading = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.i_is_loading = 1'b1;
        repeat (2) tick();
        bus.i_is_loading = 1'b0;
        tick();
        total++; if (bus.o_done !== 1'b1 || bus.o_req_valid !== 1'b0) $display("FAIL reboot_done got d=%b v=%b want d=1 v=0", bus.o_done, bus.o_req_valid); else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_cmd_allow();
        test_priority();
        test_pending();
        test_random();
        test_timeout();
        test_reset_midload();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
